mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 46 ++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults and types for the two-port memory arbiter.
// Port identifiers and the read-return tag used by the arbiter and its sub-module.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int MASK_W     = DEF_DATA_W / 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  // One slot of the read-return pipe: which port, if any, owns the data slot.
  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Grant is combinational from the requests and a registered priority pointer.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req_a,
  input  logic     req_b,
  output logic     gnt_a,
  output logic     gnt_b,
  output port_id_t gnt_port
);

  // Port that wins the next tie; it always points at the port not granted last.
  port_id_t prio_q;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    // Grants are gated by rst_n so nothing is accepted while reset is asserted.
    if (rst_n) begin
      if (req_a && (!req_b || prio_q == PORT_A)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
    gnt_port = gnt_b ? PORT_B : PORT_A;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PORT_A;
    end else if (gnt_a) begin
      prio_q <= PORT_B;
    end else if (gnt_b) begin
      prio_q <= PORT_A;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (core / debug-DMA) arbiter onto a single-port registered-read RAM.
// One access per cycle; read data returns to the owning port two cycles after grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [DATA_W/8-1:0]   a_mask,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_W-1:0]     a_rdata,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  input  logic [DATA_W/8-1:0]   b_mask,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     b_rdata,

  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_mask,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int BYTES = DATA_W / 8;

  port_id_t            gnt_port;
  logic                gnt_any;

  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BYTES-1:0]    sel_mask;

  rd_tag_t             tag1_q;
  rd_tag_t             tag2_q;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (a_req),
    .req_b    (b_req),
    .gnt_a    (a_gnt),
    .gnt_b    (b_gnt),
    .gnt_port (gnt_port)
  );

  assign gnt_any = a_gnt | b_gnt;

  // Fields of the winning port; only meaningful when gnt_any is high.
  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    sel_mask  = a_mask;
    if (gnt_port == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
      sel_mask  = b_mask;
    end
  end

  // RAM command register: enables pulse for one cycle per grant, fields hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_mask  <= '0;
    end else if (gnt_any) begin
      ram_we    <= sel_we;
      ram_re    <= !sel_we;
      ram_addr  <= sel_addr;
      ram_wdata <= sel_wdata;
      ram_mask  <= sel_we ? sel_mask : '0;
    end else begin
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
    end
  end

  // Stage 1 lines up with ram_re, stage 2 with the RAM's registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      tag1_q <= '{valid: gnt_any && !sel_we, port: gnt_port};
      tag2_q <= tag1_q;
    end
  end

  assign a_rvalid = tag2_q.valid && (tag2_q.port == PORT_A);
  assign b_rvalid = tag2_q.valid && (tag2_q.port == PORT_B);

  // Data is zeroed outside its valid cycle so an uninitialised RAM never leaks X.
  assign a_rdata = a_rvalid ? ram_rdata : '0;
  assign b_rdata = b_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural registered-read RAM.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [MW-1:0] a_mask, b_mask;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [MW-1:0] ram_mask;
  logic [DW-1:0] ram_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_mask    (a_mask),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_mask    (b_mask),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_mask  (ram_mask),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int addr);
    return 32'hC0DE_0000 | 32'(addr);
  endfunction

  // Behavioural RAM: byte-masked write, registered read, preloaded on the first edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else begin
      if (ram_we)
        for (int k = 0; k < MW; k++)
          if (ram_mask[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
      if (ram_re) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [MW-1:0] m);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_mask = m;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [MW-1:0] m);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd; b_mask = m;
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    // Reset with both ports requesting: no grants, all outputs cleared.
    rst_n = 1'b0;
    drive_a(1'b1, 1'b0, 10'h001, '0, '0);
    drive_b(1'b1, 1'b0, 10'h002, '0, '0);
    @(negedge clk); @(negedge clk); #1;
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_ram_mask", ram_mask, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);
    idle();
    rst_n = 1'b1;
    @(negedge clk);

    // Port A write then read of 0x005.
    @(negedge clk); drive_a(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF); #1;
    check("wr_a_gnt", a_gnt, 1);
    check("wr_b_gnt", b_gnt, 0);
    @(negedge clk); idle(); #1;
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_re", ram_re, 0);
    check("wr_ram_addr", ram_addr, 10'h005);
    check("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    check("wr_ram_mask", ram_mask, 4'hF);
    @(negedge clk); drive_a(1'b1, 1'b0, 10'h005, '0, 4'hF); #1;
    check("rd_a_gnt", a_gnt, 1);
    check("idle_ram_we", ram_we, 0);
    check("idle_ram_addr_hold", ram_addr, 10'h005);
    @(negedge clk); idle(); #1;
    check("rd_ram_re", ram_re, 1);
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_mask", ram_mask, 0);
    check("rd_a_rvalid_early", a_rvalid, 0);
    @(negedge clk); #1;
    check("rd_a_rvalid", a_rvalid, 1);
    check("rd_a_rdata", a_rdata, 32'hDEADBEEF);
    check("rd_b_rvalid", b_rvalid, 0);
    @(negedge clk); #1;
    check("rd_a_rvalid_done", a_rvalid, 0);

    // Port B alone streams four reads: no bubbles, data back at grant+2.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) drive_b(1'b1, 1'b0, AW'(10'h040 + i), '0, '0);
      else idle();
      #1;
      check($sformatf("bs_b_gnt%0d", i), b_gnt, logic'(i < 4));
      check($sformatf("bs_a_gnt%0d", i), a_gnt, 0);
      check($sformatf("bs_b_rvalid%0d", i), b_rvalid, logic'(i >= 2));
      if (i >= 2) check($sformatf("bs_b_rdata%0d", i), b_rdata, init_val(32'h40 + i - 2));
    end
    @(negedge clk); #1;
    check("bs_b_rvalid_done", b_rvalid, 0);

    // Both ports request for six cycles: B was granted last, so A, B, A, B, A, B.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 6) begin
        drive_a(1'b1, 1'b0, 10'h005, '0, '0);
        drive_b(1'b1, 1'b0, 10'h020, '0, '0);
      end else begin
        idle();
      end
      #1;
      if (i < 6) begin
        check($sformatf("rr_a_gnt%0d", i), a_gnt, logic'(i % 2 == 0));
        check($sformatf("rr_b_gnt%0d", i), b_gnt, logic'(i % 2 == 1));
      end
      if (i < 2) begin
        check($sformatf("rr_a_rvalid%0d", i), a_rvalid, 0);
        check($sformatf("rr_b_rvalid%0d", i), b_rvalid, 0);
      end else begin
        check($sformatf("rr_a_rvalid%0d", i), a_rvalid, logic'((i - 2) % 2 == 0));
        check($sformatf("rr_b_rvalid%0d", i), b_rvalid, logic'((i - 2) % 2 == 1));
        if ((i - 2) % 2 == 0) check($sformatf("rr_a_rdata%0d", i), a_rdata, 32'hDEADBEEF);
        else                  check($sformatf("rr_b_rdata%0d", i), b_rdata, init_val(32'h20));
      end
    end
    @(negedge clk); #1;
    check("rr_a_rvalid_done", a_rvalid, 0);
    check("rr_b_rvalid_done", b_rvalid, 0);

    // Top address: full write, byte-masked write, all-zero mask write, then read.
    @(negedge clk); drive_b(1'b1, 1'b1, 10'h3FF, 32'hAAAAAAAA, 4'hF); #1;
    check("top_gnt0", b_gnt, 1);
    @(negedge clk); drive_b(1'b1, 1'b1, 10'h3FF, 32'h11223344, 4'b0101); #1;
    check("top_gnt1", b_gnt, 1);
    check("top_ram_addr", ram_addr, 10'h3FF);
    @(negedge clk); drive_b(1'b1, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'b0000); #1;
    check("top_gnt2", b_gnt, 1);
    check("top_ram_mask0101", ram_mask, 4'b0101);
    @(negedge clk); drive_b(1'b1, 1'b0, 10'h3FF, '0, '0); #1;
    check("top_gnt3", b_gnt, 1);
    check("top_ram_we_m0", ram_we, 1);
    check("top_ram_mask0000", ram_mask, 4'b0000);
    @(negedge clk); idle(); #1;
    check("top_ram_re", ram_re, 1);
    @(negedge clk); #1;
    check("top_b_rvalid", b_rvalid, 1);
    check("top_b_rdata", b_rdata, 32'hAA22AA44);

    // Port A writes 0x010, port B reads it the very next cycle.
    @(negedge clk); drive_a(1'b1, 1'b1, 10'h010, 32'h12345678, 4'hF); #1;
    check("bb_a_gnt", a_gnt, 1);
    @(negedge clk); drive_a(1'b0, 1'b0, '0, '0, '0); drive_b(1'b1, 1'b0, 10'h010, '0, '0); #1;
    check("bb_b_gnt", b_gnt, 1);
    check("bb_a_gnt_off", a_gnt, 0);
    @(negedge clk); idle(); #1;
    check("bb_ram_re", ram_re, 1);
    check("bb_ram_addr", ram_addr, 10'h010);
    @(negedge clk); #1;
    check("bb_b_rvalid", b_rvalid, 1);
    check("bb_b_rdata", b_rdata, 32'h12345678);
    check("bb_a_rvalid", a_rvalid, 0);

    // Read granted, reset pulsed the next cycle: the read must never return.
    @(negedge clk); drive_a(1'b1, 1'b0, 10'h005, '0, '0); #1;
    check("mr_a_gnt", a_gnt, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    check("mr_ram_re", ram_re, 0);
    check("mr_a_gnt_rst", a_gnt, 0);
    @(negedge clk); #1;
    check("mr_a_rvalid_rst", a_rvalid, 0);
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("mr_a_rvalid%0d", i), a_rvalid, 0);
      check($sformatf("mr_b_rvalid%0d", i), b_rvalid, 0);
      check($sformatf("mr_ram_re%0d", i), ram_re, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
